// File: rtl/dmem_lsu.sv
// Data memory with load/store unit: byte/half/word stores and sign/zero-extending loads, with alignment and range checks.
// Responses arrive exactly RD_LATENCY cycles after accept, in order; req_ready is low only while INIT clears the array.
module dmem_lsu #(
  parameter int unsigned DEPTH_WORDS = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err
);

  localparam int unsigned IW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] dat;
    logic [1:0]  err;
  } rsp_t;

  state_t           state_q;
  logic [IW-1:0]    cnt_q;
  logic             ready_q;
  logic [3:0][7:0]  mem_q [DEPTH_WORDS];
  rsp_t             pipe_q [RD_LATENCY];
  rsp_t             pipe_d [RD_LATENCY];

  logic             accept;
  logic             wr_en;
  logic [31:0]      off;
  logic [IW-1:0]    idx;
  logic [1:0]       lane;
  logic [1:0]       err;
  logic [3:0]       be;
  logic [3:0][7:0]  wlanes;
  logic [3:0][7:0]  word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_res;

  // INIT sweeps every word to zero before the first request can be accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + IW'(1);
          if (cnt_q == IW'(DEPTH_WORDS - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

  assign accept = req_valid & ready_q;

  // Offset wraps for addresses below BASE_ADDR, so one unsigned compare covers both bounds.
  always_comb begin
    off  = req_addr - BASE_ADDR;
    idx  = off[IW+1:2];
    lane = req_addr[1:0];
    err  = 2'b00;
    if (req_size == 2'b11) begin
      err = 2'b11;
    end else if ((req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
      err = 2'b01;
    end else if (off >= SPAN) begin
      err = 2'b10;
    end
  end

  always_comb begin
    be     = 4'b0000;
    wlanes = req_wdata;
    case (req_size)
      2'b00: begin
        be     = 4'b0001 << lane;
        wlanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{req_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  assign wr_en = accept & req_we & (err == 2'b00);

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][i] <= wlanes[i];
      end
    end
  end

  // Reads see the array before this edge's write, i.e. after every earlier-accepted store.
  always_comb begin
    word    = mem_q[idx];
    ld_byte = word[lane];
    ld_half = lane[1] ? word[3:2] : word[1:0];
    case (req_size)
      2'b00:   ld_res = req_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_res = req_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_res = word;
    endcase
    if (req_we || err != 2'b00) ld_res = '0;
  end

  always_comb begin
    pipe_d[0].vld = accept;
    pipe_d[0].dat = accept ? ld_res : 32'h0;
    pipe_d[0].err = accept ? err : 2'b00;
    for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = pipe_q[RD_LATENCY-1].vld;
  assign rsp_rdata = pipe_q[RD_LATENCY-1].dat;
  assign rsp_err   = pipe_q[RD_LATENCY-1].err;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: two instances (latency 1 and 3) share stimulus; per-instance scoreboards check data, error and arrival cycle.
module tb_dmem_lsu;

  localparam logic [31:0] B = 32'h1001_0000;

  typedef struct {
    logic [31:0] dat;
    logic [1:0]  err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        ready1, ready3, r1_vld, r3_vld;
  logic [31:0] r1_dat, r3_dat;
  logic [1:0]  r1_err, r3_err;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_lsu #(.DEPTH_WORDS(16), .BASE_ADDR(B), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r1_vld), .rsp_rdata(r1_dat), .rsp_err(r1_err));

  dmem_lsu #(.DEPTH_WORDS(16), .BASE_ADDR(B), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready3), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r3_vld), .rsp_rdata(r3_dat), .rsp_err(r3_err));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (r1_vld) begin
      if (q1.size() == 0) begin
        check("lat1 unexpected rsp_valid", {31'b0, r1_vld}, 32'h0);
      end else begin
        e1 = q1.pop_front();
        check("lat1 rdata", r1_dat, e1.dat);
        check("lat1 err", {30'b0, r1_err}, {30'b0, e1.err});
        check("lat1 arrival cycle", 32'(cyc), 32'(e1.cyc));
      end
    end else begin
      check("lat1 idle rdata", r1_dat, 32'h0);
      check("lat1 idle err", {30'b0, r1_err}, 32'h0);
      if (q1.size() != 0 && q1[0].cyc <= cyc) begin
        check("lat1 missing rsp", {31'b0, r1_vld}, 32'h1);
        void'(q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (r3_vld) begin
      if (q3.size() == 0) begin
        check("lat3 unexpected rsp_valid", {31'b0, r3_vld}, 32'h0);
      end else begin
        e3 = q3.pop_front();
        check("lat3 rdata", r3_dat, e3.dat);
        check("lat3 err", {30'b0, r3_err}, {30'b0, e3.err});
        check("lat3 arrival cycle", 32'(cyc), 32'(e3.cyc));
      end
    end else begin
      check("lat3 idle rdata", r3_dat, 32'h0);
      check("lat3 idle err", {30'b0, r3_err}, 32'h0);
      if (q3.size() != 0 && q3[0].cyc <= cyc) begin
        check("lat3 missing rsp", {31'b0, r3_vld}, 32'h1);
        void'(q3.pop_front());
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] edat, input logic [1:0] eerr);
    @(negedge clk);
    check("ready at issue", {31'b0, ready1}, 32'h1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    q1.push_back('{edat, eerr, cyc + 1});
    q3.push_back('{edat, eerr, cyc + 3});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready after init", {31'b0, ready1}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset req_ready", {31'b0, ready1}, 32'h0);
    check("reset rsp_valid", {31'b0, r1_vld}, 32'h0);
    check("reset rsp_rdata", r1_dat, 32'h0);
    check("reset rsp_err", {30'b0, r1_err}, 32'h0);

    // Release: ready must stay low for exactly 16 cycles.
    rst = 1'b1;
    check("init ready low", {31'b0, ready1}, 32'h0);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check("init ready low", {31'b0, ready1}, 32'h0);
    end
    @(negedge clk);
    check("init ready high", {31'b0, ready1}, 32'h1);
    check("init ready high lat3", {31'b0, ready3}, 32'h1);

    issue(0, 2'b10, 0, B + 32'h3C, 32'h0, 32'h0000_0000, 2'b00);
    issue(0, 2'b10, 0, B,          32'h0, 32'h0000_0000, 2'b00);

    issue(1, 2'b10, 0, B + 32'h4, 32'h8081_82F3, 32'h0, 2'b00);
    issue(0, 2'b00, 0, B + 32'h4, 32'h0, 32'hFFFF_FFF3, 2'b00);
    issue(0, 2'b00, 1, B + 32'h7, 32'h0, 32'h0000_0080, 2'b00);
    issue(0, 2'b01, 0, B + 32'h6, 32'h0, 32'hFFFF_8081, 2'b00);
    issue(0, 2'b01, 1, B + 32'h4, 32'h0, 32'h0000_82F3, 2'b00);

    issue(1, 2'b00, 0, B + 32'h5, 32'hFFFF_FF55, 32'h0, 2'b00);
    issue(0, 2'b10, 0, B + 32'h4, 32'h0, 32'h8081_55F3, 2'b00);

    issue(0, 2'b01, 0, B + 32'h3,  32'h0, 32'h0, 2'b01);
    issue(0, 2'b10, 0, B + 32'h4,  32'h0, 32'h8081_55F3, 2'b00);
    issue(1, 2'b10, 0, B + 32'h40, 32'hDEAD_BEEF, 32'h0, 2'b10);
    issue(0, 2'b10, 0, B - 32'h4,  32'h0, 32'h0, 2'b10);
    issue(0, 2'b11, 0, B,          32'h0, 32'h0, 2'b11);
    issue(1, 2'b11, 0, B + 32'h4,  32'h1234_5678, 32'h0, 2'b11);
    issue(1, 2'b10, 0, B + 32'h2,  32'h1234_5678, 32'h0, 2'b01);
    issue(0, 2'b11, 0, B + 32'h41, 32'h0, 32'h0, 2'b11);
    issue(0, 2'b01, 0, B + 32'h41, 32'h0, 32'h0, 2'b01);
    issue(0, 2'b10, 0, B + 32'h4,  32'h0, 32'h8081_55F3, 2'b00);
    issue(0, 2'b10, 0, B,          32'h0, 32'h0, 2'b00);

    issue(1, 2'b01, 0, B + 32'hA, 32'h1234_BEEF, 32'h0, 2'b00);
    issue(1, 2'b00, 0, B + 32'h8, 32'h0000_007F, 32'h0, 2'b00);
    idle(2);

    // Four back-to-back loads: the latency-3 instance must answer three cycles after each accept.
    issue(0, 2'b10, 0, B + 32'h8, 32'h0, 32'hBEEF_007F, 2'b00);
    issue(0, 2'b00, 0, B + 32'hB, 32'h0, 32'hFFFF_FFBE, 2'b00);
    issue(0, 2'b01, 1, B + 32'hA, 32'h0, 32'h0000_BEEF, 2'b00);
    issue(0, 2'b00, 0, B + 32'h8, 32'h0, 32'h0000_007F, 2'b00);
    idle(6);

    // Reset with loads still in flight in the latency-3 pipeline.
    issue(0, 2'b10, 0, B + 32'h4, 32'h0, 32'h8081_55F3, 2'b00);
    issue(0, 2'b10, 0, B + 32'h8, 32'h0, 32'hBEEF_007F, 2'b00);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    rst = 1'b0;
    q1.delete();
    q3.delete();
    #1;
    check("rst drops lat3 rsp_valid", {31'b0, r3_vld}, 32'h0);
    check("rst drops lat1 rsp_valid", {31'b0, r1_vld}, 32'h0);
    check("rst clears req_ready", {31'b0, ready1}, 32'h0);
    idle(3);
    rst = 1'b1;
    wait_ready();
    issue(0, 2'b10, 0, B + 32'h4, 32'h0, 32'h0, 2'b00);
    issue(0, 2'b10, 0, B + 32'h8, 32'h0, 32'h0, 2'b00);
    idle(6);

    check("lat1 queue drained", 32'(q1.size()), 32'h0);
    check("lat3 queue drained", 32'(q3.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
